// File: rtl/shift_add_mul.sv
// Unsigned 32x32 -> 64 sequential shift-add multiplier (one result bit per RUN cycle),
// plus the 32-bit add block it is built around.

module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module shift_add_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE and out_valid only in DONE, so an operand pair can
    // never be accepted on the same edge that a product is consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [4:0]  cnt;
    logic [31:0] add_sum;
    logic        add_carry;

    // The upper half of acc is the running partial product; the lower half still holds
    // the unused multiplier bits, so acc[0] is always the current multiplier bit.
    add u_add (
        .a     (acc[63:32]),
        .b     (mcand),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign product = acc;
    assign busy    = ~in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 64'h0;
            mcand     <= 32'h0;
            cnt       <= 5'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        acc      <= {32'h0, b};
                        cnt      <= 5'd0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (acc[0]) begin
                        acc <= {add_carry, add_sum, acc[31:1]};
                    end else begin
                        acc <= {1'b0, acc[63:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: latency, corner products, back-pressure,
// mid-operation reset and back-to-back operation with in_valid held high.

module tb_shift_add_mul;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_add_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold,
                          input bit keep_valid, input bit junk);
        logic [63:0] exp;
        logic [63:0] held;
        int          lat;
        exp = {32'h0, x} * {32'h0, y};
        a = x;
        b = y;
        in_valid = 1'b1;
        chk("ready_before_accept", {63'h0, in_ready}, 64'h1);
        step();
        chk("busy_after_accept", {63'h0, busy}, 64'h1);
        chk("ready_low_in_run", {63'h0, in_ready}, 64'h0);
        if (!keep_valid) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                a = $urandom;
                b = $urandom;
            end
            step();
            lat++;
        end
        in_valid = keep_valid;
        chk("latency", 64'(lat), 64'd32);
        chk("product", product, exp);
        held = product;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", {63'h0, out_valid}, 64'h1);
            chk("hold_product", product, held);
        end
        out_ready = 1'b1;
        step();
        chk("valid_after_consume", {63'h0, out_valid}, 64'h0);
        chk("ready_after_consume", {63'h0, in_ready}, 64'h1);
        chk("busy_after_consume", {63'h0, busy}, 64'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'h0;
        b         = 32'h0;
        #12;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_product", product, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_product", product, 64'h0);

        run_op(32'd3, 32'd5, 0, 1'b0, 1'b0);
        chk("small_product_kept", product, 64'h0F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        chk("max_product_kept", product, 64'hFFFF_FFFE_0000_0001);
        // Product register must hold while idle with no request.
        step();
        step();
        chk("idle_hold", product, 64'hFFFF_FFFE_0000_0001);
        chk("idle_ready", {63'h0, in_ready}, 64'h1);

        run_op(32'h0, 32'h1234_5678, 0, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'd2, 5, 1'b0, 1'b0);
        chk("shift_product_kept", product, 64'h1_0000_0000);

        // Reset in the middle of RUN: abort with no handshake.
        a = 32'd11;
        b = 32'd13;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("run_busy_before_reset", {63'h0, busy}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_product", product, 64'h0);
        chk("midrst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {63'h0, in_ready}, 64'h1);
        run_op(32'd7, 32'd9, 0, 1'b0, 1'b0);
        chk("post_rst_product", product, 64'd63);

        // Back-to-back: in_valid stays high, each acceptance one cycle after consume.
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #60000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
